// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM states, termination causes and
// the default tohost mailbox address.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    TIMEOUT = 3'd3,
    HANG    = 3'd4
  } cause_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  // Bit order matches the flag registers: {hang, timeout, fail, pass}.
  function automatic logic [3:0] cause_onehot(input cause_t c);
    case (c)
      PASS:    return 4'b0001;
      FAIL:    return 4'b0010;
      TIMEOUT: return 4'b0100;
      HANG:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/run_ctrl_pc_stall_det.sv
// Tracks how many consecutive run cycles the core has presented the same pc.
// stall is combinational from pc so the caller can register it with the cycle.
module pc_stall_det #(
  parameter int STALL_LIMIT = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clr,
  input  logic [31:0] pc,
  output logic        stall
);

  localparam logic [31:0] LIMIT = 32'(STALL_LIMIT);

  logic [31:0] prev_pc;
  logic [31:0] run_len;
  logic [31:0] run_len_nxt;

  // run_len==0 marks "no valid previous pc" right after entering RUN.
  always_comb begin
    run_len_nxt = 32'd1;
    if ((run_len != 32'd0) && (pc == prev_pc)) begin
      run_len_nxt = run_len + 32'd1;
    end
  end

  assign stall = (LIMIT != 32'd0) && (run_len_nxt >= LIMIT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_pc <= 32'd0;
      run_len <= 32'd0;
    end else if (clr) begin
      prev_pc <= pc;
      run_len <= 32'd0;
    end else begin
      prev_pc <= pc;
      run_len <= run_len_nxt;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, runs it against a cycle budget and
// reports pass/fail/timeout/hang; every output is registered, no backpressure.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          RST_CYCLES  = 4,
  parameter logic [31:0] MAX_CYCLES  = 32'd20,
  parameter int          STALL_LIMIT = 8,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int          DATA_W      = 64,
  localparam int         MASK_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [31:0]       pc,
  input  logic [31:0]       addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic              core_nrst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              hang,
  output logic [DATA_W-2:0] exit_code,
  output logic [31:0]       cycle_cnt
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

  state_t      state;
  logic [7:0]  rst_cnt;
  logic        stall;
  logic        mbox_hit;
  logic [31:0] cnt_nxt;
  cause_t      cause;
  logic        unused_bits;

  pc_stall_det #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk  (clk),
    .nrst (nrst),
    .clr  (state != RUN),
    .pc   (pc),
    .stall(stall)
  );

  // Any byte address inside the mailbox doubleword counts as a hit.
  assign mbox_hit = wr_en && (addr[31:3] == TOHOST_ADDR[31:3]) && wmask[0] && wdata[0];
  assign cnt_nxt  = cycle_cnt + 32'd1;
  assign unused_bits = ^{addr[2:0], wmask[MASK_W-1:1]};

  always_comb begin
    cause = NONE;
    if (mbox_hit) begin
      cause = (wdata[DATA_W-1:1] == '0) ? PASS : FAIL;
    end else if (stall) begin
      cause = HANG;
    end else if (cnt_nxt == MAX_CYCLES) begin
      cause = TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      rst_cnt   <= 8'd0;
      core_nrst <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      hang      <= 1'b0;
      exit_code <= '0;
      cycle_cnt <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RESET;
            rst_cnt   <= RST_LOAD;
            done      <= 1'b0;
            {hang, timeout, fail, pass} <= 4'b0000;
            exit_code <= '0;
            cycle_cnt <= 32'd0;
          end
        end
        RESET: begin
          done      <= 1'b0;
          {hang, timeout, fail, pass} <= 4'b0000;
          exit_code <= '0;
          cycle_cnt <= 32'd0;
          if (rst_cnt == 8'd0) begin
            state     <= RUN;
            core_nrst <= 1'b1;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end
        RUN: begin
          // The terminating cycle itself is counted.
          cycle_cnt <= cnt_nxt;
          if (cause != NONE) begin
            state     <= DONE;
            core_nrst <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b1;
            {hang, timeout, fail, pass} <= cause_onehot(cause);
            if (mbox_hit) begin
              exit_code <= wdata[DATA_W-1:1];
            end
          end
        end
        default: begin
          state     <= IDLE;
          core_nrst <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl; termination results go through a scoreboard
// queue that a negedge monitor drains on each rising done.
module tb_run_ctrl;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] addr;
  logic        wr_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        core_nrst;
  logic        running;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic        hang;
  logic [62:0] exit_code;
  logic [31:0] cycle_cnt;

  run_ctrl #(
    .RST_CYCLES (4),
    .MAX_CYCLES (32'd20),
    .STALL_LIMIT(8),
    .TOHOST_ADDR(32'h0000_1000),
    .DATA_W     (64)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .pc       (pc),
    .addr     (addr),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .wmask    (wmask),
    .core_nrst(core_nrst),
    .running  (running),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .hang     (hang),
    .exit_code(exit_code),
    .cycle_cnt(cycle_cnt)
  );

  typedef struct {
    logic [3:0]  flags;
    logic [62:0] code;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total;
  int   bad;
  logic done_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // One RUN cycle: present inputs, let the edge pass, drop the write strobe.
  task automatic cyc(input logic [31:0] p, input logic we, input logic [31:0] a,
                     input logic [63:0] d, input logic [7:0] m);
    pc = p; wr_en = we; addr = a; wdata = d; wmask = m;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_run();
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!core_nrst && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_len", 128'(n), 128'd4);
    chk("run_entry", {running, done, pass, fail, timeout, hang}, 6'b100000);
    chk("run_clear", {exit_code, cycle_cnt}, 128'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", done, 1'b1);
  endtask

  // Scoreboard monitor.
  initial begin
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_seen) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done: got done=1, want no termination");
        end else begin
          e = exp_q.pop_front();
          chk("sb_flags", {hang, timeout, fail, pass}, e.flags);
          chk("sb_exit_code", exit_code, e.code);
          chk("sb_cycle_cnt", cycle_cnt, e.cnt);
          chk("sb_core_frozen", {core_nrst, running}, 2'b00);
        end
      end
      done_seen = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    nrst = 1'b0; start = 1'b0; pc = 32'h0; addr = 32'h0;
    wr_en = 1'b0; wdata = 64'h0; wmask = 8'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals", {core_nrst, running, done, pass, fail, timeout, hang}, 7'b0);
    chk("reset_regs", {exit_code, cycle_cnt}, 128'd0);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", {core_nrst, running, done}, 3'b000);

    // Pass at RUN cycle 9, with a stray start mid-run.
    start_run();
    for (int c = 0; c < 9; c++) begin
      if (c == 3) start = 1'b1;
      cyc(32'h100 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
      start = 1'b0;
      if (c == 3) chk("start_in_run", {running, core_nrst, done}, 3'b110);
    end
    exp_q.push_back('{4'b0001, 63'd0, 32'd10});
    cyc(32'h124, 1'b1, 32'h1000, 64'h1, 8'h01);
    wait_done(4);

    // Fail via same doubleword; even wdata ignored.
    start_run();
    for (int c = 0; c < 3; c++) cyc(32'h200 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
    cyc(32'h20c, 1'b1, 32'h1000, 64'h6, 8'h01);
    chk("even_wdata_ignored", done, 1'b0);
    exp_q.push_back('{4'b0010, 63'd3, 32'd5});
    cyc(32'h210, 1'b1, 32'h1004, 64'h7, 8'h01);
    wait_done(4);

    // Timeout after 20 RUN cycles.
    start_run();
    exp_q.push_back('{4'b0100, 63'd0, 32'd20});
    for (int c = 0; c < 20; c++) begin
      cyc(32'h300 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
      if (c == 18) chk("pre_timeout", done, 1'b0);
    end
    wait_done(4);

    // Mailbox on the last budget cycle beats timeout; masked/off-address writes ignored.
    start_run();
    exp_q.push_back('{4'b0001, 63'd0, 32'd20});
    for (int c = 0; c < 19; c++) begin
      if (c == 5) cyc(32'h400 + 32'(4 * c), 1'b1, 32'h1008, 64'h1, 8'h01);
      else if (c == 10) cyc(32'h400 + 32'(4 * c), 1'b1, 32'h1000, 64'h1, 8'hFE);
      else cyc(32'h400 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
    end
    chk("ignored_writes", done, 1'b0);
    cyc(32'h4f0, 1'b1, 32'h1000, 64'h1, 8'h01);
    wait_done(4);

    // Hang: pc frozen at 0x40 for 8 cycles.
    start_run();
    exp_q.push_back('{4'b1000, 63'd0, 32'd11});
    for (int c = 0; c < 3; c++) cyc(32'h500 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
    for (int c = 3; c < 11; c++) begin
      cyc(32'h40, 1'b0, 32'h0, 64'h0, 8'h0);
      if (c == 9) chk("hang_not_early", done, 1'b0);
    end
    wait_done(4);

    // Seven frozen cycles then movement: no hang, run ends by timeout.
    start_run();
    exp_q.push_back('{4'b0100, 63'd0, 32'd20});
    for (int c = 0; c < 20; c++) begin
      if (c >= 2 && c <= 8) cyc(32'h40, 1'b0, 32'h0, 64'h0, 8'h0);
      else cyc(32'h600 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
      if (c == 9) chk("no_hang_7", done, 1'b0);
    end
    wait_done(4);

    // Asynchronous reset mid-run.
    start_run();
    for (int c = 0; c < 5; c++) cyc(32'h700 + 32'(4 * c), 1'b0, 32'h0, 64'h0, 8'h0);
    chk("pre_nrst_cnt", cycle_cnt, 32'd5);
    nrst = 1'b0;
    #1;
    chk("async_reset_vals", {core_nrst, running, done, pass, fail, timeout, hang}, 7'b0);
    chk("async_reset_regs", {exit_code, cycle_cnt}, 128'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle", {core_nrst, running}, 2'b00);

    // Earliest possible termination: mailbox on RUN cycle 0.
    start_run();
    exp_q.push_back('{4'b0001, 63'd0, 32'd1});
    cyc(32'h800, 1'b1, 32'h1000, 64'h1, 8'h01);
    wait_done(4);

    repeat (3) @(negedge clk);
    chk("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
